// File: rtl/tick_stretcher_pkg.sv
// Shared types and elaboration-time helpers for the tick stretcher.
package tick_stretcher_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StGap  = 2'd2
  } state_e;

  // Evaluated in 64 bits so large clock/time products do not wrap.
  function automatic longint unsigned us_to_cycles(input longint unsigned freq,
                                                   input longint unsigned us);
    return (freq * us) / 64'd1_000_000;
  endfunction

  function automatic bit cycles_valid(input longint unsigned cycles);
    return cycles >= 64'd1;
  endfunction

endpackage

// File: rtl/tick_stretcher_interval_timer.sv
// Interval timer shared by the HOLD and GAP phases; done flags the last counted cycle.
module tick_stretcher_interval_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] term_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  assign done_o = enable_i && (cnt_q == term_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_stretcher.sv
// Stretches single-cycle ticks into fixed-length visible pulses separated by an off gap,
// queueing ticks that arrive while a pulse is in progress.
module tick_stretcher
  import tick_stretcher_pkg::*;
#(
  parameter int unsigned ClkFreq      = 100_000_000,
  parameter int unsigned HoldTimeUs   = 100_000,
  parameter int unsigned GapTimeUs    = 50_000,
  parameter int unsigned PendingDepth = 7
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              tick_i,
  output logic                              pulse_o,
  output logic                              busy_o,
  output logic [$clog2(PendingDepth+1)-1:0] pending_o,
  output logic                              overflow_o
);

  localparam longint unsigned HoldCycles = us_to_cycles(64'(ClkFreq), 64'(HoldTimeUs));
  localparam longint unsigned GapCycles  = us_to_cycles(64'(ClkFreq), 64'(GapTimeUs));
  localparam longint unsigned MaxCycles  = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int unsigned     TimerW     = (MaxCycles > 64'd1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned     PendW      = $clog2(PendingDepth + 1);

  localparam logic [TimerW-1:0] HoldTerm = TimerW'(HoldCycles - 64'd1);
  localparam logic [TimerW-1:0] GapTerm  = TimerW'(GapCycles - 64'd1);
  localparam logic [PendW-1:0]  PendMax  = PendW'(PendingDepth);

  if (!cycles_valid(HoldCycles) || !cycles_valid(GapCycles) || PendingDepth < 1)
  begin : gen_bad_cfg
    $error("tick_stretcher: hold/gap must be >= 1 cycle and PendingDepth >= 1");
  end

  state_e            state_q, state_d;
  logic [PendW-1:0]  pend_q, pend_d;
  logic              pulse_q, busy_q, ovf_q, ovf_d;
  logic [TimerW-1:0] timer_term;
  logic              timer_done, tick_enq;

  tick_stretcher_interval_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (state_d != state_q),
    .enable_i(state_q != StIdle),
    .term_i  (timer_term),
    .done_o  (timer_done)
  );

  // A tick on the last GAP cycle is handled by the restart logic, not the queue.
  assign tick_enq = tick_i && ((state_q == StHold) || (state_q == StGap && !timer_done));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    ovf_d      = 1'b0;
    timer_term = (state_q == StGap) ? GapTerm : HoldTerm;

    unique case (state_q)
      StIdle: if (tick_i) state_d = StHold;
      StHold: if (timer_done) state_d = StGap;
      StGap: begin
        if (timer_done) begin
          state_d = (pend_q != '0 || tick_i) ? StHold : StIdle;
          if (pend_q != '0 && !tick_i) pend_d = pend_q - PendW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (tick_enq) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PendW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pulse_q <= (state_d == StHold);
      busy_q  <= (state_d != StIdle);
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_o    = pulse_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_tick_stretcher.sv
// Scoreboard bench for tick_stretcher: timeline model of pulses/queue vs. DUT outputs.
module tb_tick_stretcher;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int D    = 2;
  localparam int NCyc = 4096;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic       pulse_o, busy_o, overflow_o;
  logic [1:0] pending_o;

  tick_stretcher #(
    .ClkFreq     (1_000_000),
    .HoldTimeUs  (4),
    .GapTimeUs   (2),
    .PendingDepth(2)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_i    (tick_i),
    .pulse_o   (pulse_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model: start cycle of the latest pulse and number of queued ticks.
  int s_start = -100;
  int q_pend  = 0;
  int start_q[$];
  int ovf_q[$];
  bit exp_valid[NCyc];
  bit exp_pulse[NCyc];
  bit exp_busy[NCyc];
  bit exp_ovf[NCyc];
  int exp_pend[NCyc];
  int pulse_cnt = 0;
  int ovf_cnt   = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Inputs seen in cycle c determine outputs visible in cycle c+1.
  task automatic model_step(input int c, input bit t, input bit rn);
    int last;
    bit ovf;
    bit restart;
    ovf  = 1'b0;
    last = s_start + H + G - 1;
    if (!rn) begin
      s_start = -100;
      q_pend  = 0;
    end else if (c == last) begin
      restart = (q_pend > 0) || t;
      if (q_pend > 0 && !t) q_pend--;
      if (restart) begin
        s_start = c + 1;
        start_q.push_back(c + 1);
      end
    end else if (c >= s_start && c < last) begin
      if (t) begin
        if (q_pend < D) q_pend++;
        else begin
          ovf = 1'b1;
          ovf_q.push_back(c + 1);
        end
      end
    end else if (t) begin
      s_start = c + 1;
      start_q.push_back(c + 1);
    end
    if (c + 1 < NCyc) begin
      exp_valid[c+1] = 1'b1;
      exp_pulse[c+1] = (c + 1 >= s_start) && (c + 1 < s_start + H);
      exp_busy[c+1]  = (c + 1 >= s_start) && (c + 1 <= s_start + H + G - 1);
      exp_pend[c+1]  = q_pend;
      exp_ovf[c+1]   = ovf;
    end
  endtask

  // Monitor: per-cycle levels plus scoreboard pops on pulse rise and overflow.
  initial begin
    bit prev_pulse;
    int exp_c;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk_i);
      if (cyc < NCyc && exp_valid[cyc]) begin
        check("pulse_level", int'(pulse_o), int'(exp_pulse[cyc]));
        check("busy_level", int'(busy_o), int'(exp_busy[cyc]));
        check("pending", int'(pending_o), exp_pend[cyc]);
        check("overflow_level", int'(overflow_o), int'(exp_ovf[cyc]));
      end
      if (pulse_o && !prev_pulse) begin
        pulse_cnt++;
        if (start_q.size() == 0) check("pulse_unexpected", cyc, -1);
        else begin
          exp_c = start_q.pop_front();
          check("pulse_start", cyc, exp_c);
        end
      end
      prev_pulse = pulse_o;
      if (overflow_o) begin
        ovf_cnt++;
        if (ovf_q.size() == 0) check("overflow_unexpected", cyc, -1);
        else begin
          exp_c = ovf_q.pop_front();
          check("overflow_cycle", cyc, exp_c);
        end
      end
    end
  end

  task automatic step(input bit t, input bit rn);
    tick_i = t;
    rst_ni = rn;
    model_step(cyc, t, rn);
    @(posedge clk_i);
    #1;
  endtask

  task automatic scenario(input string name, input logic [39:0] tmask, input logic [39:0] rmask,
                          input int exp_pulses, input int exp_ovfs);
    int p0;
    int o0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    p0 = pulse_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 40; i++) step(tmask[i], !rmask[i]);
    check({name, "_pulses"}, pulse_cnt - p0, exp_pulses);
    check({name, "_overflows"}, ovf_cnt - o0, exp_ovfs);
  endtask

  initial begin
    logic [39:0] b;
    b = 40'd1;
    @(posedge clk_i);
    #1;
    scenario("single", b << 10, '0, 1, 0);
    scenario("burst", (b << 10) | (b << 12) | (b << 13) | (b << 14), '0, 3, 1);
    scenario("gap_last_pend", (b << 10) | (b << 12) | (b << 16), '0, 3, 0);
    scenario("gap_last_direct", (b << 10) | (b << 16), '0, 2, 0);
    scenario("mid_reset", (b << 10) | (b << 12), b << 12, 1, 0);
    scenario("held_high", (b << 10) | (b << 11) | (b << 12) | (b << 13) | (b << 14), '0, 3, 2);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    check("pulses_left", start_q.size(), 0);
    check("overflows_left", ovf_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_stretcher.md
Name: tick_stretcher

Overview:
Output-side counterpart of the input debouncer. It converts single-cycle event ticks from the core clock domain into human-visible pulses of fixed length, separated by a guaranteed off gap. Ticks that arrive while a pulse is showing are queued in a saturating pending counter, so each burst event is shown as its own blink. It sits between control logic and board LEDs or buzzers.

Parameters:
ClkFreq, 100_000_000, core clock frequency in Hz.
HoldTimeUs, 100_000, on-time of each visible pulse, in microseconds.
GapTimeUs, 50_000, minimum off-time after each pulse, in microseconds.
PendingDepth, 7, maximum number of queued ticks; must be >= 1.

Ports:
clk_i  input  1  core clock, all logic on rising edge.
rst_ni  input  1  synchronous, active-low reset.
tick_i  input  1  single-cycle event request; level-high for N cycles counts as N ticks.
pulse_o  output  1  stretched visible pulse, registered.
busy_o  output  1  high whenever state is not IDLE, registered.
pending_o  output  $clog2(PendingDepth+1)  number of queued ticks not yet shown.
overflow_o  output  1  one-cycle pulse when a tick is dropped because the queue is full.

Behaviour:
- Derived constants: HoldCycles = ClkFreq*HoldTimeUs/1_000_000 and GapCycles = ClkFreq*GapTimeUs/1_000_000.
- Evaluate both products in 64-bit arithmetic. Elaboration error if either result is < 1.
- A single timer counter is sized for max(HoldCycles, GapCycles). It is reloaded to 0 on every state entry.
- Reset (rst_ni=0 sampled at a clock edge): state IDLE, timer 0, pending 0, pulse_o=0, busy_o=0, overflow_o=0. The reset takes effect at that edge even mid-HOLD or mid-GAP. tick_i is ignored while reset is asserted.
- States: IDLE, HOLD, GAP.
- IDLE:
  - tick_i=1 -> HOLD at the next edge.
  - Latency is 1 cycle: pulse_o rises on the edge after the tick.
- HOLD:
  - pulse_o=1 for exactly HoldCycles cycles.
  - On the last cycle (timer == HoldCycles-1) -> GAP.
- GAP:
  - pulse_o=0 for exactly GapCycles cycles.
  - On the last cycle: if pending>0 or tick_i=1 -> HOLD, with no IDLE cycle in between; otherwise -> IDLE.
- Queueing:
  - A tick_i in HOLD, or in GAP before the last cycle, increments pending.
  - If pending == PendingDepth, the tick is dropped, pending holds, and overflow_o=1 on the next cycle.
- GAP last cycle, simultaneous events:
  - pending>0 and tick_i=1: pending unchanged (increment and decrement cancel).
  - pending>0 and tick_i=0: pending decrements.
  - pending==0 and tick_i=1: the tick is consumed directly, pending stays 0.
- Entering HOLD from IDLE never touches pending.
- busy_o is the registered decode of state != IDLE, so it is aligned with pulse_o.
- No tick is ever lost except through a reported overflow.

Decomposition:
- Package tick_stretcher_pkg holds:
  - the state enum typedef (IDLE, HOLD, GAP) in 2-bit logic;
  - a function us_to_cycles(freq, us) returning a 64-bit cycle count;
  - the elaboration check helper.
- One natural sub-module, interval_timer:
  - inputs: clear, enable, terminal value;
  - output: done, asserted on the last count.
  - Reused for both HOLD and GAP.
- The FSM and the pending counter stay in tick_stretcher.

Test Plan:
All scenarios use ClkFreq=1_000_000, HoldTimeUs=4, GapTimeUs=2, PendingDepth=2 (HoldCycles=4, GapCycles=2).
1. Single tick at cycle 10 -> pulse_o=1 cycles 11-14; pulse_o=0 cycles 15-16 with busy_o=1; busy_o=0 from cycle 17; pending_o stays 0.
2. Ticks at cycles 10, 12, 13, 14 -> pending_o goes 1, then 2; the tick at 14 is dropped and overflow_o=1 at cycle 15; exactly 3 pulses total, starting at 11, 17 and 23.
3. Tick at 10, tick at 12 (pending=1), then tick at cycle 16 (last GAP cycle) -> pending_o stays 1 and the second pulse starts at cycle 17; a third pulse follows at 23; pending_o=0 from cycle 17+6.
4. Tick at 10, then tick only at cycle 16 (pending=0) -> HOLD re-entered at 17 with no IDLE cycle; pending_o=0 throughout.
5. Tick at 10, rst_ni=0 during cycle 12 with tick_i=1 -> pulse_o=0, busy_o=0 and pending_o=0 from cycle 13; no further pulse after reset is released.
6. tick_i held high for 5 cycles from IDLE -> 1 pulse immediately plus 4 requests: pending saturates at 2, 2 overflow_o pulses, 3 pulses shown in total.
